// File: rtl/ccip_mmio_initiator.sv
// CCI-P type subset plus a host-side MMIO initiator: turns a command/response
// handshake into AFU Rx c0 MMIO requests and collects Tx c2 read responses.
package ccip_if_pkg;

    localparam int unsigned CCIP_CLDATA_W = 512;
    localparam int unsigned CCIP_MMIO_W   = 64;
    localparam int unsigned CCIP_TID_W    = 9;
    localparam int unsigned CCIP_ADDR_W   = 16;

    typedef struct packed {
        logic [CCIP_ADDR_W-1:0] address;
        logic [1:0]             length;
        logic                   rsvd;
        logic [CCIP_TID_W-1:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic        format;
        logic        rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        logic [CCIP_TID_W-1:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr       hdr;
        logic [CCIP_CLDATA_W-1:0] data;
        logic                     rspValid;
        logic                     mmioRdValid;
        logic                     mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [63:0] hdr;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [63:0]              hdr;
        logic [CCIP_CLDATA_W-1:0] data;
        logic                     valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr    hdr;
        logic                   mmioRdValid;
        logic [CCIP_MMIO_W-1:0] data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

endpackage

module ccip_mmio_initiator
    import ccip_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [63:0] TIMEOUT_DATA   = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [63:0] cmd_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic        resp_timeout,
    output t_if_ccip_Rx afu_rx,
    input  t_if_ccip_Tx afu_tx
);

    localparam int unsigned TID_W  = CCIP_TID_W;
    localparam int unsigned DATA_W = CCIP_MMIO_W;
    localparam int unsigned CL_W   = CCIP_CLDATA_W;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [TID_W-1:0]    tid_q, tid_d;
    logic [TID_W-1:0]    flight_tid_q, flight_tid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cmd_ready_d;
    logic                resp_valid_d;
    logic [DATA_W-1:0]   resp_data_d;
    logic                resp_timeout_d;
    t_if_ccip_Rx         afu_rx_d;
    t_ccip_c0_ReqMmioHdr issue_hdr;
    logic                rsp_match;
    logic                cnt_last;

    // c0/c1 Tx channels and the DW address LSB carry nothing this block needs.
    logic unused_inputs;
    assign unused_inputs = ^{afu_tx.c0, afu_tx.c1, cmd_addr[0]};

    // Next-state and registered-output decode
    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        tid_d          = tid_q;
        flight_tid_d   = flight_tid_q;
        cnt_d          = cnt_q;
        cmd_ready_d    = 1'b0;
        resp_valid_d   = 1'b0;
        resp_data_d    = '0;
        resp_timeout_d = 1'b0;
        afu_rx_d       = '0;
        issue_hdr      = '0;
        rsp_match      = afu_tx.c2.mmioRdValid && (afu_tx.c2.hdr.tid == flight_tid_q);
        cnt_last       = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    write_d      = cmd_write;
                    flight_tid_d = tid_q;
                    // Request is built here so it appears registered during ISSUE.
                    issue_hdr.address       = {cmd_addr[15:1], 1'b0};
                    issue_hdr.length        = 2'b01;
                    issue_hdr.tid           = tid_q;
                    afu_rx_d.c0.hdr         = t_ccip_c0_RspMemHdr'(issue_hdr);
                    afu_rx_d.c0.mmioWrValid = cmd_write;
                    afu_rx_d.c0.mmioRdValid = !cmd_write;
                    afu_rx_d.c0.data        = cmd_write ? CL_W'(cmd_wdata) : '0;
                    state_d                 = ISSUE;
                end
            end
            ISSUE: begin
                tid_d = tid_q + TID_W'(1);
                cnt_d = '0;
                if (write_q) begin
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rsp_match) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = afu_tx.c2.data;
                    state_d      = DONE;
                end else if (cnt_last) begin
                    resp_valid_d   = 1'b1;
                    resp_timeout_d = 1'b1;
                    resp_data_d    = TIMEOUT_DATA;
                    state_d        = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            tid_q        <= '0;
            flight_tid_q <= '0;
            cnt_q        <= '0;
            cmd_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_timeout <= 1'b0;
            afu_rx       <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            tid_q        <= tid_d;
            flight_tid_q <= flight_tid_d;
            cnt_q        <= cnt_d;
            cmd_ready    <= cmd_ready_d;
            resp_valid   <= resp_valid_d;
            resp_data    <= resp_data_d;
            resp_timeout <= resp_timeout_d;
            afu_rx       <= afu_rx_d;
        end
    end

endmodule

// File: tb/tb_ccip_mmio_initiator.sv
// Directed + randomized bench for ccip_mmio_initiator with a transaction-level
// reference model (expected tid sequence, response cycle, data and timeout).
module tb_ccip_mmio_initiator;
    import ccip_if_pkg::*;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_timeout;
    t_if_ccip_Rx afu_rx;
    t_if_ccip_Tx afu_tx;

    ccip_mmio_initiator #(
        .TIMEOUT_CYCLES(T),
        .TIMEOUT_DATA  (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_timeout(resp_timeout),
        .afu_rx      (afu_rx),
        .afu_tx      (afu_tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          k;
        logic [8:0]  tid;
        logic [63:0] data;
    } rsp_t;

    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tid_m = 0;
    int   prev_accept = 0;
    int   prev_l = 0;
    bit   prev_hold = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Responder: noise on ignored channels, scheduled c2 responses by cycle index.
    task automatic drive_tx(input int k);
        afu_tx.c0.hdr         = {$urandom(), $urandom()};
        afu_tx.c0.valid       = 1'($urandom_range(0, 1));
        afu_tx.c1.hdr         = {$urandom(), $urandom()};
        afu_tx.c1.data        = {16{$urandom()}};
        afu_tx.c1.valid       = 1'($urandom_range(0, 1));
        afu_tx.c2.mmioRdValid = 1'b0;
        afu_tx.c2.hdr.tid     = 9'(tid_m);
        afu_tx.c2.data        = {$urandom(), $urandom()};
        foreach (rsp_q[i]) begin
            if (rsp_q[i].k == k) begin
                afu_tx.c2.mmioRdValid = 1'b1;
                afu_tx.c2.hdr.tid     = rsp_q[i].tid;
                afu_tx.c2.data        = rsp_q[i].data;
            end
        end
    endtask

    task automatic push_rsp(input int k, input int tid, input logic [63:0] data);
        rsp_t r;
        r.k    = k;
        r.tid  = 9'(tid);
        r.data = data;
        rsp_q.push_back(r);
    endtask

    // One command; k counts cycles after the accepting edge (k=1 is the request cycle).
    task automatic run_cmd(input bit wr, input logic [15:0] addr, input logic [63:0] wd,
                           input bit hold);
        int                  l;
        int                  acc;
        int                  bound;
        bit                  to;
        bit                  found;
        logic [63:0]         exp_data;
        logic [8:0]          my_tid;
        t_ccip_c0_ReqMmioHdr h;

        my_tid   = 9'(tid_m);
        l        = 2;
        exp_data = 64'd0;
        to       = 1'b0;
        if (!wr) begin
            l        = int'(T) + 2;
            exp_data = 64'hFFFF_FFFF_FFFF_FFFF;
            to       = 1'b1;
            found    = 1'b0;
            for (int kk = 2; kk <= int'(T) + 1; kk++) begin
                foreach (rsp_q[i]) begin
                    if (!found && rsp_q[i].k == kk && rsp_q[i].tid == my_tid) begin
                        found    = 1'b1;
                        l        = kk + 1;
                        exp_data = rsp_q[i].data;
                        to       = 1'b0;
                    end
                end
            end
        end

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        bound     = 0;
        while (cmd_ready !== 1'b1 && bound < 50) begin
            @(negedge clk);
            drive_tx(-1);
            bound++;
        end
        if (bound >= 50) begin
            chk("accept_bound", 64'(0), 64'(1));
            cmd_valid = 1'b0;
            rsp_q.delete();
            return;
        end
        acc = cyc + 1;
        if (prev_hold) chk("cmd_spacing", 64'(acc - prev_accept), 64'(prev_l + 1));

        for (int k = 1; k <= l + 1; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) cmd_valid = 1'b0;
            drive_tx(k);
            chk("mmio_wr_valid", 64'(afu_rx.c0.mmioWrValid), 64'((k == 1) && wr));
            chk("mmio_rd_valid", 64'(afu_rx.c0.mmioRdValid), 64'((k == 1) && !wr));
            chk("rx_unused", 64'({afu_rx.c0TxAlmFull, afu_rx.c1TxAlmFull,
                                  afu_rx.c0.rspValid, afu_rx.c1 !== '0}), 64'(0));
            if (k == 1) begin
                h = t_ccip_c0_ReqMmioHdr'(afu_rx.c0.hdr);
                chk("hdr_address", 64'(h.address), 64'({addr[15:1], 1'b0}));
                chk("hdr_length", 64'(h.length), 64'(2'b01));
                chk("hdr_tid", 64'(h.tid), 64'(my_tid));
                chk("rx_data_lo", afu_rx.c0.data[63:0], wr ? wd : 64'd0);
                chk("rx_data_hi", 64'(afu_rx.c0.data[511:64] !== '0), 64'(0));
            end
            chk("resp_valid", 64'(resp_valid), 64'(k == l));
            chk("cmd_ready", 64'(cmd_ready), 64'(k == l + 1));
            if (k == l) begin
                chk("resp_data", resp_data, exp_data);
                chk("resp_timeout", 64'(resp_timeout), 64'(to));
            end
        end

        tid_m       = (tid_m + 1) % 512;
        prev_accept = acc;
        prev_l      = l;
        prev_hold   = hold;
        rsp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          wr;
        int          kr;
        logic [15:0] a;
        logic [63:0] d;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        afu_tx    = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_timeout", 64'(resp_timeout), 64'(0));
        chk("rst_afu_rx", 64'(afu_rx !== '0), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

        // Basic write, then reads answered one cycle after the request
        run_cmd(1'b1, 16'h0020, 64'h1234_5678_9ABC_DEF0, 1'b0);
        push_rsp(2, tid_m, 64'h1234_5678_9ABC_DEF0);
        run_cmd(1'b0, 16'h0020, 64'h0, 1'b0);
        push_rsp(1, tid_m, 64'hDEAD_DEAD_DEAD_DEAD);
        push_rsp(2, tid_m, 64'h0BAD_CAFE_0000_0021);
        run_cmd(1'b0, 16'h0021, 64'hFFFF_0000_FFFF_0000, 1'b0);

        // Wrong tid first, correct tid two cycles later
        push_rsp(2, tid_m + 1, 64'hAAAA);
        push_rsp(4, tid_m, 64'h5555);
        run_cmd(1'b0, 16'h0100, 64'h0, 1'b0);

        // Timeout, then a late response for that tid during IDLE and the next read
        push_rsp(int'(T) + 3, tid_m, 64'h1111_2222_3333_4444);
        run_cmd(1'b0, 16'h0200, 64'h0, 1'b0);
        push_rsp(2, tid_m - 1, 64'hBAD0_BAD0_BAD0_BAD0);
        push_rsp(3, tid_m, 64'h0123_4567_89AB_CDEF);
        run_cmd(1'b0, 16'h0202, 64'h0, 1'b0);

        // Back-to-back writes with cmd_valid held
        run_cmd(1'b1, 16'h0300, 64'hA5A5_A5A5_0000_0001, 1'b1);
        run_cmd(1'b1, 16'h0304, 64'h5A5A_5A5A_0000_0002, 1'b0);

        // 512 randomized commands held back-to-back: tid wraps through 511 -> 0
        for (int i = 0; i < 512; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 16'($urandom());
            d  = {$urandom(), $urandom()};
            if (!wr) begin
                kr = $urandom_range(2, 5);
                if ($urandom_range(0, 3) == 0) push_rsp(kr - 1, tid_m + 1, {$urandom(), $urandom()});
                if ($urandom_range(0, 7) != 0) push_rsp(kr, tid_m, {$urandom(), $urandom()});
            end
            run_cmd(wr, a, d, i != 511);
        end
        chk("tid_model_wrapped", 64'(tid_m), 64'((8 + 512) % 512));
        run_cmd(1'b1, 16'h0400, 64'h0000_0000_0000_0400, 1'b0);

        // Reset during the third WAIT cycle of a read
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0500;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            drive_tx(-1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midwait_rst_afu_rx", 64'(afu_rx !== '0), 64'(0));
        chk("midwait_rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("midwait_rst_cmd_ready", 64'(cmd_ready), 64'(0));
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_resp_valid", 64'(resp_valid), 64'(0));
            chk("post_rst_ready", 64'(cmd_ready), 64'(1));
        end
        tid_m     = 0;
        prev_hold = 1'b0;
        run_cmd(1'b1, 16'h0600, 64'hCAFE_F00D_CAFE_F00D, 1'b0);
        push_rsp(2, tid_m, 64'h7777_8888_9999_AAAA);
        run_cmd(1'b0, 16'h0601, 64'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
